// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared float32 field positions, argmax FSM states and score compare
// Build option: ARGMAX_SIGNED_CMP_EN selects full signed float ordering in fp_ge.
package cnn_pkg;

  localparam int DATAWIDTH = 32;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int MAN_MSB   = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } argmax_state_t;

  // True when score a ranks at or above score b.
  function automatic logic fp_ge(input logic [DATAWIDTH-1:0] a, input logic [DATAWIDTH-1:0] b);
    logic [EXP_MSB-EXP_LSB:0] exp_a, exp_b;
    logic [MAN_MSB:0]         man_a, man_b;
    logic                     result;
    exp_a = a[EXP_MSB:EXP_LSB];
    exp_b = b[EXP_MSB:EXP_LSB];
    man_a = a[MAN_MSB:0];
    man_b = b[MAN_MSB:0];
`ifdef ARGMAX_SIGNED_CMP_EN
    if (a[EXP_MSB:0] == '0 && b[EXP_MSB:0] == '0) begin
      result = 1'b1;
    end else if (a[DATAWIDTH-1] != b[DATAWIDTH-1]) begin
      result = ~a[DATAWIDTH-1];
    end else if (a[DATAWIDTH-1]) begin
      // Both negative: the smaller magnitude is the larger value.
      result = (exp_a != exp_b) ? (exp_a < exp_b) : (man_a <= man_b);
    end else begin
      result = (exp_a != exp_b) ? (exp_a > exp_b) : (man_a >= man_b);
    end
`else
    result = (exp_a != exp_b) ? (exp_a > exp_b) : (man_a >= man_b);
`endif
    return result;
  endfunction

endpackage

// File: rtl/fp_max_cmp.sv
// rtl/fp_max_cmp.sv - combinational two-input score max; equal scores select input 2
// Ordering follows cnn_pkg::fp_ge (ARGMAX_SIGNED_CMP_EN aware).
module fp_max_cmp
  import cnn_pkg::*;
#(
  parameter int DW   = 32,
  parameter int IDXW = 4
) (
  input  logic [DW-1:0]   value1,
  input  logic [IDXW-1:0] index1,
  input  logic [DW-1:0]   value2,
  input  logic [IDXW-1:0] index2,
  output logic [DW-1:0]   max_value,
  output logic [IDXW-1:0] max_index
);

  logic take2;

  always_comb begin
    take2     = fp_ge(value2, value1);
    max_value = take2 ? value2 : value1;
    max_index = take2 ? index2 : index1;
  end

endmodule

// File: rtl/argmax_sequencer.sv
// rtl/argmax_sequencer.sv - streams NUM_CLASSES scores through one max compare, pulses done
// Build option: ARGMAX_SIGNED_CMP_EN (signed float ordering, via cnn_pkg::fp_ge).
module argmax_sequencer
  import cnn_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDXW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 rd_en,
  output logic [IDXW-1:0]      rd_addr,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0] max_value,
  output logic [IDXW-1:0]      max_index,
  output logic                 done
);

  localparam logic [IDXW-1:0] LAST_ADDR = IDXW'(NUM_CLASSES - 1);

  argmax_state_t        state;
  logic                 data_valid;
  logic [IDXW-1:0]      data_idx;
  logic                 have_max;
  logic [DATAWIDTH-1:0] cmp_value;
  logic [IDXW-1:0]      cmp_index;

  fp_max_cmp #(
    .DW   (DATAWIDTH),
    .IDXW (IDXW)
  ) u_cmp (
    .value1    (max_value),
    .index1    (max_index),
    .value2    (rd_data),
    .index2    (data_idx),
    .max_value (cmp_value),
    .max_index (cmp_index)
  );

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      data_valid <= 1'b0;
      data_idx   <= '0;
      have_max   <= 1'b0;
      max_value  <= '0;
      max_index  <= '0;
    end else begin
      // rd_data returns one cycle after the strobe, tagged with the address it came from.
      data_valid <= rd_en;
      data_idx   <= rd_addr;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            have_max <= 1'b0;
          end
        end
        RUN: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN:   state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (data_valid) begin
        have_max  <= 1'b1;
        max_value <= have_max ? cmp_value : rd_data;
        max_index <= have_max ? cmp_index : data_idx;
      end
    end
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
// tb/tb_argmax_sequencer.sv - randomized and directed checks of argmax_sequencer against an argmax model
// Expected results follow ARGMAX_SIGNED_CMP_EN when the bench is built with it.
module tb_argmax_sequencer;

  localparam int N = 10;

  logic        clk;
  logic        rst_n;
  logic        start, start1;
  logic        busy, busy1;
  logic        rd_en, rd_en1;
  logic [3:0]  rd_addr, rd_addr1;
  logic [31:0] rd_data, rd_data1;
  logic [31:0] max_value, max_value1;
  logic [3:0]  max_index, max_index1;
  logic        done, done1;

  logic [31:0] mem [16];
  logic [31:0] mem1;

  int vectors;
  int miscompares;

  argmax_sequencer #(.DATAWIDTH(32), .NUM_CLASSES(N), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .max_value(max_value),
    .max_index(max_index), .done(done)
  );

  argmax_sequencer #(.DATAWIDTH(32), .NUM_CLASSES(1), .IDXW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .rd_en(rd_en1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .max_value(max_value1),
    .max_index(max_index1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Score buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (rd_en1) rd_data1 <= mem1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ranking key: a larger key is a larger score.
  function automatic longint score_key(input logic [31:0] v);
    longint mag;
    mag = longint'({33'd0, v[30:0]});
`ifdef ARGMAX_SIGNED_CMP_EN
    return v[31] ? -mag : mag;
`else
    return mag;
`endif
  endfunction

  function automatic int model_idx();
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if (score_key(mem[i]) >= score_key(mem[best])) best = i;
    return best;
  endfunction

  task automatic run_frame(input string name, input bit mid_start, input bit fin_start);
    int          exp_idx;
    logic [31:0] exp_val;
    exp_idx = model_idx();
    exp_val = mem[exp_idx];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      chk({name, ".rd_en"}, 32'(rd_en), 32'(c <= N));
      if (c <= N) chk({name, ".rd_addr"}, 32'(rd_addr), 32'(c - 1));
      chk({name, ".busy"}, 32'(busy), 32'(c <= N + 1));
      chk({name, ".done"}, 32'(done), 32'(c == N + 2));
      if (c >= N + 2) begin
        chk({name, ".max_index"}, 32'(max_index), 32'(exp_idx));
        chk({name, ".max_value"}, max_value, exp_val);
      end
      start = (mid_start && c == 4) || (fin_start && c == N + 2);
    end
    start = 1'b0;
  endtask

  task automatic run_single(input logic [31:0] val);
    mem1 = val;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("n1.rd_en", 32'(rd_en1), 32'(c == 1));
      chk("n1.busy", 32'(busy1), 32'(c == 1 || c == 2));
      chk("n1.done", 32'(done1), 32'(c == 3));
      if (c >= 3) begin
        chk("n1.max_index", 32'(max_index1), 32'd0);
        chk("n1.max_value", max_value1, val);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mem1   = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rd_en", 32'(rd_en), 32'd0);
    chk("rst.rd_addr", 32'(rd_addr), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.max_value", max_value, 32'd0);
    chk("rst.max_index", 32'(max_index), 32'd0);
    chk("rst.n1_done", 32'(done1), 32'd0);
    rst_n = 1'b1;

    // 1.0, 2.0, 3.5, 0.5, then small values; a stray start at cycle 4 must be ignored.
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000; mem[2] = 32'h40600000;
    mem[3] = 32'h3F000000;
    for (int i = 4; i < N; i++) mem[i] = 32'h3E800000 + 32'(i);
    chk("basic.model", 32'(model_idx()), 32'd2);
    run_frame("basic", 1'b1, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 32'h3F800000;
    mem[7] = 32'h3F800001;
    run_frame("mantissa", 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = 32'h3F800000;
    run_frame("ties", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 32'hBF800000;
    mem[0] = 32'hC1000000;
    mem[1] = 32'h3E800000;
    run_frame("signs", 1'b0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) begin
        if (f % 2 == 0) mem[i] = $urandom;
        else mem[i] = {1'($urandom), 8'(127 + $urandom_range(0, 1)), 23'($urandom_range(0, 3))};
      end
      run_frame("random", f % 3 == 0, f % 4 == 1);
    end

    // Reset in cycle 5 of a frame aborts it with no done pulse.
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.rd_en", 32'(rd_en), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.rd_addr", 32'(rd_addr), 32'd0);
    chk("abort.max_value", max_value, 32'd0);
    chk("abort.max_index", 32'(max_index), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      chk("abort.no_done", 32'(done), 32'd0);
      chk("abort.idle", 32'(rd_en), 32'd0);
    end

    run_frame("after_abort", 1'b0, 1'b0);

    run_single(32'h40000000);
    run_single($urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
